// File: rtl/int_ctrl.sv
// Interrupt controller: per-source edge capture into pending, enable masking,
// fixed priority (index 0 highest) and a request/ack/mret handshake toward the core.
// Optional `INTC_SYNC_EN adds a 2-flop synchronizer on every irq line.

module int_src (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic clr,
    output logic pend
);
    logic irq_s;
    logic irq_q;

`ifdef INTC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], irq_in};
    end

    assign irq_s = sync_q[1];
`else
    assign irq_s = irq_in;
`endif

    // A fresh edge beats a clear landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            irq_q <= irq_s;
            if (irq_s & ~irq_q) pend <= 1'b1;
            else if (clr)       pend <= 1'b0;
        end
    end
endmodule

module int_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq,
    input  logic         int_ack,
    input  logic         mret,
    output logic         INT,
    input  logic         cs,
    input  logic         we,
    input  logic [3:0]   addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

    state_t       state, state_d;
    logic [N-1:0] pending, enable, req, clr, cause_dec;
    logic [4:0]   cause_id, cause_d, sel_id;
    logic         in_service, insvc_d, int_d, ack_clr, req_hit;
    logic         wr_pend, wr_en;
    logic         unused_bits;

    assign unused_bits = ^{addr[1:0], wdata};

    assign wr_pend = cs & we & (addr[3:2] == 2'd0);
    assign wr_en   = cs & we & (addr[3:2] == 2'd1);
    assign req     = pending & enable;

    int_src u_src [N-1:0] (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq),
        .clr    (clr),
        .pend   (pending)
    );

    always_comb begin
        sel_id = 5'd0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) sel_id = 5'(i);
    end

    always_comb begin
        cause_dec = '0;
        for (int i = 0; i < N; i++)
            cause_dec[i] = (cause_id == 5'(i));
    end

    assign req_hit = |(req & cause_dec);
    assign clr     = ({N{wr_pend}} & wdata[N-1:0]) | ({N{ack_clr}} & cause_dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) enable <= '0;
        else if (wr_en) enable <= wdata[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cause_id   <= 5'd0;
            in_service <= 1'b0;
            INT        <= 1'b0;
        end else begin
            state      <= state_d;
            cause_id   <= cause_d;
            in_service <= insvc_d;
            INT        <= int_d;
        end
    end

    always_comb begin
        state_d = state;
        cause_d = cause_id;
        insvc_d = in_service;
        int_d   = INT;
        ack_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ASSERT;
                    cause_d = sel_id;
                    int_d   = 1'b1;
                end
            end
            S_ASSERT: begin
                if (int_ack) begin
                    ack_clr = 1'b1;
                    int_d   = 1'b0;
                    insvc_d = 1'b1;
                    state_d = S_SERVICE;
                end else if (!req_hit) begin
                    // Request withdrawn by a clear or disable before the core took it.
                    int_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (mret) begin
                    insvc_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (cs) begin
            case (addr[3:2])
                2'd0:    rdata = 32'(pending);
                2'd1:    rdata = 32'(enable);
                2'd2:    rdata = {in_service, 26'd0, cause_id};
                default: rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (N=8, no synchronizer): edge capture, priority,
// ack/mret handshake, enable masking, withdrawal, set-vs-clear and async reset.

module tb_int_ctrl;
    localparam int N = 8;
    localparam logic [3:0] A_PEND = 4'h0, A_EN = 4'h4, A_CAUSE = 4'h8, A_RSV = 4'hC;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic         int_ack, mret, INT, cs, we;
    logic [3:0]   addr;
    logic [31:0]  wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .int_ack (int_ack),
        .mret    (mret),
        .INT     (INT),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        cs = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(tag, rdata, exp);
        cs = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; int_ack = 1'b0; mret = 1'b0;
        cs = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'd0;
        tick(); tick();
        chk("reset_int", {31'd0, INT}, 32'd0);
        rd_chk("reset_cause", A_CAUSE, 32'd0);
        rst = 1'b0;
        tick();

        // Single source, full handshake
        wr(A_EN, 32'h01);
        irq = 8'h01; tick(); irq = 8'h00;
        rd_chk("t1_pending", A_PEND, 32'h01);
        chk("t1_int_lat", {31'd0, INT}, 32'd0);
        tick();
        chk("t1_int", {31'd0, INT}, 32'd1);
        rd_chk("t1_cause", A_CAUSE, 32'h0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t1_ack_int", {31'd0, INT}, 32'd0);
        rd_chk("t1_ack_pend", A_PEND, 32'h0);
        rd_chk("t1_ack_cause", A_CAUSE, 32'h8000_0000);
        mret = 1'b1; tick(); mret = 1'b0;
        rd_chk("t1_mret_cause", A_CAUSE, 32'h0);

        // Two sources at once: priority, then reassert after mret
        wr(A_EN, 32'hFF);
        irq = 8'h0A; tick(); irq = 8'h00;
        tick();
        chk("t2_int", {31'd0, INT}, 32'd1);
        rd_chk("t2_cause1", A_CAUSE, 32'h1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd_chk("t2_ack_pend", A_PEND, 32'h08);
        rd_chk("t2_ack_cause", A_CAUSE, 32'h8000_0001);
        tick();
        chk("t2_svc_noint", {31'd0, INT}, 32'd0);
        mret = 1'b1; tick(); mret = 1'b0;
        chk("t2_mret_int", {31'd0, INT}, 32'd0);
        tick();
        chk("t2_reassert", {31'd0, INT}, 32'd1);
        rd_chk("t2_cause3", A_CAUSE, 32'h3);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        mret = 1'b1; tick(); mret = 1'b0;
        rd_chk("t2_clean_pend", A_PEND, 32'h0);

        // Masked event, then enable it
        wr(A_EN, 32'h00);
        irq = 8'h04; tick(); irq = 8'h00;
        tick();
        rd_chk("t3_pend", A_PEND, 32'h04);
        chk("t3_masked", {31'd0, INT}, 32'd0);
        wr(A_EN, 32'h04);
        chk("t3_en_lat", {31'd0, INT}, 32'd0);
        tick();
        chk("t3_int", {31'd0, INT}, 32'd1);
        rd_chk("t3_cause", A_CAUSE, 32'h2);

        // Withdraw in ASSERT by clearing pending; a late ack is ignored
        wr(A_PEND, 32'h04);
        rd_chk("t4_pend_clr", A_PEND, 32'h0);
        tick();
        chk("t4_withdraw", {31'd0, INT}, 32'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t4_ack_ign", {31'd0, INT}, 32'd0);
        rd_chk("t4_cause", A_CAUSE, 32'h2);

        // Edge beats same-cycle clear; plain clear works
        wr(A_EN, 32'h00);
        irq = 8'h01;
        wr(A_PEND, 32'h01);
        irq = 8'h00;
        rd_chk("t5_set_wins", A_PEND, 32'h01);
        wr(A_PEND, 32'h01);
        rd_chk("t5_clear", A_PEND, 32'h0);

        // Register map boundaries
        wr(A_EN, 32'hFFFF_FFFF);
        rd_chk("map_en_width", A_EN, 32'hFF);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd_chk("map_rsv", A_RSV, 32'h0);
        cs = 1'b0; addr = A_EN; #1;
        chk("map_cs0", rdata, 32'h0);
        wr(A_EN, 32'h00);

        // Async reset while in SERVICE
        wr(A_EN, 32'h03);
        irq = 8'h01; tick(); irq = 8'h00;
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 8'h02; tick(); irq = 8'h00;
        rd_chk("t6_svc_cause", A_CAUSE, 32'h8000_0000);
        rd_chk("t6_svc_pend", A_PEND, 32'h02);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_int", {31'd0, INT}, 32'd0);
        rd_chk("t6_rst_pend", A_PEND, 32'h0);
        rd_chk("t6_rst_en", A_EN, 32'h0);
        rd_chk("t6_rst_cause", A_CAUSE, 32'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6_post_int", {31'd0, INT}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the single-cycle RISC-V core: collects up to N peripheral interrupt lines, latches rising edges into a pending register, masks them with a software-written enable register, and drives the core's single `INT` request. It is the source side of the core's interrupt interface, sequencing request, acknowledge (trap entry) and `mret` (trap exit). It also responds on the core's data bus as a small memory-mapped register block.

## Interface
Parameters:
- `N`, 8: number of interrupt sources, 1..31.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq`  in  N  peripheral interrupt lines; rising edge = event.
- `int_ack`  in  1  one-cycle pulse from the core when it vectors to the trap handler.
- `mret`  in  1  one-cycle pulse when the core executes `mret`.
- `INT`  out  1  registered interrupt request to the core.
- `cs`  in  1  bus select for this block.
- `we`  in  1  bus write strobe; qualified by `cs`.
- `addr`  in  4  byte address; `addr[3:2]` selects the word.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  combinational read data.

## Operation
- Edge detect: `irq_q` holds the previous cycle's sample. `edge = irq_s & ~irq_q`, where `irq_s` is `irq`, or its synchronized copy (see Configuration).
- Pending: a bit sets on `edge`. It clears on a bus write-1 to PENDING, or when its request is acknowledged. Set wins over clear in the same cycle.
- `req = pending & enable`. `sel_id` is the lowest-index set bit of `req`, so index 0 has the highest priority.
- FSM states:
  - IDLE: if `req != 0`, go to ASSERT, latch `cause_id <= sel_id`, and set `INT <= 1`.
  - ASSERT: on `int_ack`, clear `pending[cause_id]` (unless it re-edges in the same cycle), set `INT <= 0`, set `in_service <= 1`, and go to SERVICE. Otherwise, if `req[cause_id] == 0` (the request was withdrawn by a clear or disable), set `INT <= 0` and go to IDLE.
  - SERVICE: on `mret`, set `in_service <= 0` and go to IDLE. New events only accumulate in pending; there is no nesting.
- Ignored inputs: `int_ack` outside ASSERT and `mret` outside SERVICE.
- Register map (`addr[3:2]`):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write; bits at index N and above read 0.
  - 2 CAUSE: read-only, `{in_service, 26'b0, cause_id[4:0]}`.
  - 3: reads 0; writes ignored.
  - `rdata` is 0 when `cs = 0`.
- Reset values: `pending = 0`, `enable = 0`, `cause_id = 0`, `in_service = 0`, `INT = 0`, state IDLE, `irq_q` and synchronizer flops at 0. A source held high through reset therefore registers one edge after reset releases.
- Reset mid-operation (any state): return immediately to IDLE with `INT = 0`. All pending events are lost.

## Timing
- `irq[i]` rising before clock edge k (no sync): `pending[i] = 1` after edge k. `INT = 1` after edge k+1 if enabled and the FSM is in IDLE.
- `int_ack` sampled at edge m: `INT = 0` and the pending bit is cleared after edge m.
- `mret` at edge m: the FSM is in IDLE after m. If another request is still outstanding, `INT` reasserts after edge m+1.
- A bus write to ENABLE or PENDING at edge m takes effect on `req` after edge m.
- `INT` is always a flop output with no combinational path from inputs.

## Configuration
- `INTC_SYNC_EN`:
  - Defined: each `irq` bit passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of latency, so `pending` sets after edge k+2 and `INT` rises after edge k+3.
  - Undefined: `irq` is used directly. The lines must already be synchronous to `clk`.

## Test plan
- Reset, then ENABLE = 0x01 and a pulse on `irq[0]` -> PENDING = 0x01 one edge later, `INT = 1` the next edge, CAUSE = 0x00000000.
- `irq[3]` and `irq[1]` rise in the same cycle, ENABLE = 0xFF -> `cause_id = 1`. After `int_ack`: PENDING = 0x08 and CAUSE = 0x80000001. After `mret`: `INT` reasserts with `cause_id = 3`.
- ENABLE = 0x00 with an `irq[2]` edge -> PENDING = 0x04 and `INT` stays 0. Writing ENABLE = 0x04 -> `INT = 1` one edge later.
- In ASSERT with `cause_id = 2`, write PENDING = 0x04 -> `INT = 0` and FSM in IDLE. An `int_ack` afterwards changes nothing.
- Same-cycle `irq[0]` edge and write-1-clear of PENDING bit 0 -> PENDING bit 0 remains 1.
- Assert `rst` while in SERVICE -> `INT = 0` and PENDING/ENABLE/CAUSE read 0 immediately, without waiting for a clock edge.
